// File: rtl/ray_node_sched.sv
// Walks the valid children of one BVH node through a single ray_box_unit and reports hit mask and nearest hit.
// Latency: k*(L+1)+1 cycles for k valid children with box-unit latency L (1 cycle for an empty mask); one request in flight.
// Backpressure: node_ready only in IDLE; request fields hold until box_req_ready; result holds until res_ready.
module ray_node_sched #(
    parameter int FP_W    = 32,
    parameter int FP_FRAC = 16,
    parameter int N_CHILD = 4,
    localparam int IDX_W  = (N_CHILD > 1) ? $clog2(N_CHILD) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      node_valid,
    output logic                      node_ready,
    input  logic [11*FP_W-1:0]        node_ray,
    input  logic [N_CHILD*6*FP_W-1:0] node_boxes,
    input  logic [N_CHILD-1:0]        node_mask,
    output logic                      box_req_valid,
    input  logic                      box_req_ready,
    output logic [11*FP_W-1:0]        box_req_ray,
    output logic [6*FP_W-1:0]         box_req_box,
    input  logic                      box_resp_valid,
    output logic                      box_resp_ready,
    input  logic                      box_resp_hit,
    input  logic [FP_W-1:0]           box_resp_t_enter,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [N_CHILD-1:0]        res_hit_mask,
    output logic                      res_any_hit,
    output logic [IDX_W-1:0]          res_nearest_idx,
    output logic [FP_W-1:0]           res_nearest_t
);

    localparam int BOX_W = 6 * FP_W;
    localparam int INT_W = FP_W - FP_FRAC;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                    state, state_nxt;
    logic [11*FP_W-1:0]        ray_q;
    logic [N_CHILD*BOX_W-1:0]  boxes_q;
    logic [N_CHILD-1:0]        mask_q;
    logic [N_CHILD-1:0]        hit_q;
    logic [IDX_W-1:0]          idx_q;
    logic [IDX_W-1:0]          near_idx_q;
    logic [INT_W+FP_FRAC-1:0]  near_t_q;   // signed Q(INT_W).(FP_FRAC) distance

    logic                      node_acc;
    logic [IDX_W-1:0]          first_idx;
    logic                      nxt_found;
    logic [IDX_W-1:0]          nxt_idx;
    logic                      take_near;

    // Lowest set bit of the incoming mask and next set bit above the current child.
    always_comb begin
        first_idx = '0;
        for (int i = N_CHILD - 1; i >= 0; i--) begin
            if (node_mask[i]) first_idx = IDX_W'(i);
        end
    end

    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = N_CHILD - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(idx_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(i);
            end
        end
    end

    // Strict less-than keeps the earlier (lower-index) child on equal distances.
    assign take_near = box_resp_hit &&
                       ((hit_q == '0) || ($signed(box_resp_t_enter) < $signed(near_t_q)));

    assign node_acc = node_valid && node_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (node_acc)       state_nxt = (node_mask == '0) ? DONE : ISSUE;
            ISSUE: if (box_req_ready)  state_nxt = WAIT;
            WAIT:  if (box_resp_valid) state_nxt = nxt_found ? ISSUE : DONE;
            DONE:  if (res_ready)      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        node_ready     = (state == IDLE) && !rst;
        box_req_valid  = (state == ISSUE);
        box_resp_ready = (state == WAIT);
        res_valid      = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ray_q      <= '0;
            boxes_q    <= '0;
            mask_q     <= '0;
            hit_q      <= '0;
            idx_q      <= '0;
            near_idx_q <= '0;
            near_t_q   <= '0;
        end else if (node_acc) begin
            ray_q      <= node_ray;
            boxes_q    <= node_boxes;
            mask_q     <= node_mask;
            hit_q      <= '0;
            idx_q      <= first_idx;
            near_idx_q <= '0;
            near_t_q   <= '0;
        end else if (state == WAIT && box_resp_valid) begin
            if (box_resp_hit) hit_q[idx_q] <= 1'b1;
            if (take_near) begin
                near_idx_q <= idx_q;
                near_t_q   <= box_resp_t_enter;
            end
            if (nxt_found) idx_q <= nxt_idx;
        end
    end

    assign box_req_ray     = ray_q;
    assign box_req_box     = boxes_q[int'(idx_q) * BOX_W +: BOX_W];
    assign res_hit_mask    = hit_q;
    assign res_any_hit     = |hit_q;
    assign res_nearest_idx = near_idx_q;
    assign res_nearest_t   = near_t_q;

endmodule

// File: doc/ray_node_sched.md
RAY_NODE_SCHED -- requirements
Module: ray_node_sched

Interface
REQ-001 SHALL have parameter FP_W, default 32, fixed-point word width.
REQ-002 SHALL have parameter FP_FRAC, default 16, fractional bits (Q16.16).
REQ-003 SHALL have parameter N_CHILD, default 4, maximum child boxes per node.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port list:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- node_valid  in  1  node request valid.
- node_ready  out  1  scheduler can accept a node.
- node_ray  in  11*FP_W  ray_t {origin, dir, inv_dir, t_min, t_max}.
- node_boxes  in  N_CHILD*6*FP_W  aabb_t array; child i at bits [i*6*FP_W +: 6*FP_W].
- node_mask  in  N_CHILD  child i valid when bit i is set.
- box_req_valid  out  1  request to ray_box_unit.
- box_req_ready  in  1  ray_box_unit accepts.
- box_req_ray  out  11*FP_W  latched ray.
- box_req_box  out  6*FP_W  current child box.
- box_resp_valid  in  1  ray_box_unit result valid.
- box_resp_ready  out  1  scheduler accepts result.
- box_resp_hit  in  1  hit flag.
- box_resp_t_enter  in  FP_W  signed entry distance.
- res_valid  out  1  node result valid.
- res_ready  in  1  consumer accepts result.
- res_hit_mask  out  N_CHILD  bit i set if child i hit.
- res_any_hit  out  1  OR of res_hit_mask.
- res_nearest_idx  out  $clog2(N_CHILD)  index of nearest hit child.
- res_nearest_t  out  FP_W  signed t_enter of nearest hit.

Function
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-007 IDLE: node_ready=1. On node_valid&&node_ready, latch ray, boxes and mask, and clear hit_mask, nearest_idx and nearest_t. If mask==0, go to DONE; otherwise set idx=lowest set bit and go to ISSUE.
REQ-008 ISSUE: box_req_valid=1 and box_req_box=boxes[idx]. box_req_ray and box_req_box SHALL be held stable until box_req_ready. On box_req_ready, go to WAIT.
REQ-009 WAIT: box_resp_ready=1. On box_resp_valid:
- if box_resp_hit, set hit_mask[idx];
- update the nearest hit if hit && (no prior hit || t_enter < nearest_t), using a signed compare; on ties, the lower index wins;
- if a set mask bit exists above idx, set idx to the next one and go to ISSUE; otherwise go to DONE.
REQ-010 DONE: res_valid=1. Result outputs SHALL be held stable until res_ready. On res_ready, go to IDLE.
REQ-011 At most one box request SHALL be outstanding. box_resp_ready=0 outside WAIT, and box_resp_valid outside WAIT SHALL be ignored.
REQ-012 node_ready, box_req_valid, box_resp_ready and res_valid SHALL be mutually exclusive per state as above.
REQ-013 If no child hits: res_any_hit=0, res_nearest_idx=0, res_nearest_t=0.
REQ-014 Latency, with box_req_ready=1, res_ready=1, box unit responding L>=1 cycles after accept, k set mask bits: res_valid asserts k*(L+1)+1 cycles after node accept (mask==0: 1 cycle).
REQ-015 Children SHALL be issued in ascending index order. Non-set bits SHALL be skipped with no bubble cycle.

Reset
REQ-016 While rst=1: state=IDLE and every output =0, including node_ready=0.
REQ-017 Reset mid-operation SHALL drop the in-flight node with no result. A box response arriving after reset release SHALL be ignored.
REQ-018 node_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-019 Use ray origin (0,0,-5), dir/inv_dir (0,0,1), t [0,100]. Children: 0=box z[3,4] (t=8), 1=box (-1,-1,0)-(1,1,2) (t=5), 2=box x[5,6] (miss). mask=0111 -> hit_mask=0011, any_hit=1, nearest_idx=1, nearest_t=0x0005_0000.
REQ-020 mask=0000 -> res_valid 1 cycle after accept, no box_req_valid, all result fields 0.
REQ-021 Tie: children 0 and 3 = box (-1,-1,0)-(1,1,2), mask=1001 -> hit_mask=1001, nearest_idx=0, t=5.0. Only children 0 and 3 are issued.
REQ-022 Backpressure: box_req_ready held low 3 cycles -> box_req_valid/box stable. res_ready low 4 cycles -> result stable, node_ready=0.
REQ-023 rst pulsed in WAIT -> all outputs 0 immediately. A late box_resp_valid is ignored. Next node completes correctly.
REQ-024 Latency check with behavioural responder L=3, mask=1111 -> res_valid exactly 17 cycles after accept.
